nq_exec_ctrl: RTL and testbench
===============================

Name: nq_exec_ctrl

Overview:
Multi-cycle execute/memory controller for the NanoQuarter execute datapath (ALU, memory mux, next-PC adder). It accepts one decoded instruction (op/funct) at a time and sequences execute, memory handshake and write-back. It drives the datapath's regwrite/memread/memwrite/jmp/jr/bne controls and next-PC select, and stalls the front end while busy. It flushes the front end on taken control transfers.

Parameters:
MEM_TIMEOUT, 15, max cycles in MEM waiting for mem_ack before abort (1..255)
TO_W, 8, width of timeout counter

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-low (asserted when 0)
instr_valid  in  1  decoded instruction present on op_in/funct_in
instr_ready  out  1  controller can accept; equals (state==IDLE)
op_in  in  2  00 R-type, 01 I-type, 10 J-type, 11 BNE
funct_in  in  3  function code
bne_cond  in  1  reg1data != reg2data from datapath comparator
mem_ack  in  1  memory completion, sampled only in MEM
mem_req  out  1  memory request, held until ack or timeout
mem_byte  out  1  byte access (LB/SB/SBI)
memread  out  1  datapath memread / mmux select memory
memwrite  out  1  datapath memwrite
regwrite  out  1  one-cycle write-back pulse
jmp  out  1  jump control to datapath
jr  out  1  jump-register control
bne  out  1  branch control
pc_sel  out  2  00 PC+2, 01 PC+jtarget, 10 PC+reg1data, 11 PC+boffset
flush  out  1  one-cycle front-end flush
stall  out  1  = ~instr_ready
timeout_err  out  1  sticky; set on memory timeout

Behaviour:
- Reset (rst=0, async): state IDLE; every output 0 except instr_ready=1; timeout counter 0; timeout_err cleared.
- Decode classes: R (op 00, all funct): ALU, regwrite. I op 01: funct 000 LUI and 001 LBI -> ALU, regwrite; 010 SUI and 011 SBI -> store immediate (memwrite; mem_byte for SBI); 100 LW and 101 LB -> load (memread, regwrite; mem_byte for LB); 110 SW and 111 SB -> store (mem_byte for SB). J op 10: funct 000 JMP, 001 JR, others treated as NOP. BR op 11: BNE.
- States: IDLE, EXEC, MEM, WB.
- IDLE: when instr_valid=1, latch op/funct and go to EXEC. Otherwise stay.
- EXEC: lasts exactly one cycle.
  - ALU class -> WB.
  - Memory class -> MEM.
  - J and BR -> IDLE.
- JMP in EXEC: jmp=1, pc_sel=01, flush=1.
- JR in EXEC: jr=1, pc_sel=10, flush=1.
- BNE in EXEC: bne=1. If bne_cond=1, pc_sel=11 and flush=1. If bne_cond=0, pc_sel=00 and flush=0.
- MEM:
  - mem_req=1, with memread/memwrite/mem_byte held constant for the whole state.
  - Counter increments each MEM cycle.
  - Ack in a cycle with req high completes the access: load -> WB, store -> IDLE.
  - If the counter reaches MEM_TIMEOUT without ack: drop req, set timeout_err, go IDLE, no regwrite.
  - Ack and timeout in the same cycle: ack wins.
  - mem_ack outside MEM is ignored.
- WB: regwrite=1 for one cycle, memread stays 1 for loads so the memory mux holds memory data; then IDLE.
- pc_sel is 00 and jmp/jr/bne are 0 in every state other than EXEC of a J/BR instruction.
- Latency from accept to regwrite: ALU ops 2 cycles; loads 3+N cycles, where N = ack wait.
- Throughput: one instruction per 3 cycles for ALU ops, 2 for jumps.
- instr_valid while busy is not consumed; the front end must hold it stable.
- Reset mid-operation aborts immediately. No write-back or memory request survives it.

Decomposition:
- Package nq_ctrl_pkg holds:
  - OP_R/OP_I/OP_J/OP_BR.
  - Funct constants (NAND..SUB, LUI, LBI, SUI, SBI, LW, LB, SW, SB, JMP, JR).
  - PC_SEL_* codes.
  - State encoding.
- Sub-module nq_ctrl_decode: combinational (op, funct) -> class, is_load, is_store, is_byte, wb_en. The FSM instantiates it on the latched op/funct.

Test Plan:
- Reset: drive rst=0 at t=3ns mid-cycle -> all outputs 0 and instr_ready=1 without waiting for clk; release -> IDLE.
- R-type ADD: op=00, funct=101, valid for 1 cycle -> EXEC next cycle, regwrite=1 exactly 2 cycles after accept, stall high for 2 cycles, pc_sel=00 throughout.
- LW: op=01, funct=100, mem_ack after 3 MEM cycles -> mem_req high 3 cycles, memread=1 through WB, regwrite pulse in cycle after ack, mem_byte=0.
- SB timeout: op=01, funct=111, MEM_TIMEOUT=4, no ack -> mem_req and mem_byte high 4 cycles, then timeout_err=1 sticky, no regwrite, instr_ready=1.
- Control transfers:
  - JMP (op 10, funct 000) -> EXEC with jmp=1, pc_sel=01, flush=1.
  - JR (funct 001) -> jr=1, pc_sel=10.
  - BNE with bne_cond=1 -> pc_sel=11, flush=1; with bne_cond=0 -> pc_sel=00, flush=0.
- Back-to-back: SUI immediately followed by LBI with valid held high -> second accepted only on the IDLE cycle after SUI's ack; a spurious mem_ack in IDLE is ignored.

Source files
------------

// File: rtl/nq_ctrl_pkg.sv
// rtl/nq_ctrl_pkg.sv - shared opcodes, function codes, pc-select codes and state encoding
package nq_ctrl_pkg;

  localparam logic [1:0] OP_R  = 2'b00;
  localparam logic [1:0] OP_I  = 2'b01;
  localparam logic [1:0] OP_J  = 2'b10;
  localparam logic [1:0] OP_BR = 2'b11;

  // R-type function codes
  localparam logic [2:0] F_NAND = 3'b000;
  localparam logic [2:0] F_OR   = 3'b001;
  localparam logic [2:0] F_AND  = 3'b010;
  localparam logic [2:0] F_NOR  = 3'b011;
  localparam logic [2:0] F_XOR  = 3'b100;
  localparam logic [2:0] F_ADD  = 3'b101;
  localparam logic [2:0] F_SLT  = 3'b110;
  localparam logic [2:0] F_SUB  = 3'b111;

  // I-type function codes
  localparam logic [2:0] F_LUI = 3'b000;
  localparam logic [2:0] F_LBI = 3'b001;
  localparam logic [2:0] F_SUI = 3'b010;
  localparam logic [2:0] F_SBI = 3'b011;
  localparam logic [2:0] F_LW  = 3'b100;
  localparam logic [2:0] F_LB  = 3'b101;
  localparam logic [2:0] F_SW  = 3'b110;
  localparam logic [2:0] F_SB  = 3'b111;

  // J-type function codes
  localparam logic [2:0] F_JMP = 3'b000;
  localparam logic [2:0] F_JR  = 3'b001;

  localparam logic [1:0] PC_SEL_PC2  = 2'b00;
  localparam logic [1:0] PC_SEL_JMP  = 2'b01;
  localparam logic [1:0] PC_SEL_REG  = 2'b10;
  localparam logic [1:0] PC_SEL_BOFF = 2'b11;

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_EXEC = 2'b01;
  localparam logic [1:0] S_MEM  = 2'b10;
  localparam logic [1:0] S_WB   = 2'b11;

  typedef enum logic [1:0] {
    CLS_NOP  = 2'b00,
    CLS_ALU  = 2'b01,
    CLS_MEM  = 2'b10,
    CLS_CTRL = 2'b11
  } nq_class_e;

endpackage

// File: rtl/nq_ctrl_decode.sv
// rtl/nq_ctrl_decode.sv - combinational instruction class decode
module nq_ctrl_decode
  import nq_ctrl_pkg::*;
(
  input  logic [1:0] op,
  input  logic [2:0] funct,
  output logic [1:0] cls,
  output logic       is_load,
  output logic       is_store,
  output logic       is_byte,
  output logic       wb_en
);

  always_comb begin
    cls      = CLS_NOP;
    is_load  = 1'b0;
    is_store = 1'b0;
    is_byte  = 1'b0;
    wb_en    = 1'b0;
    case (op)
      OP_R: begin
        cls   = CLS_ALU;
        wb_en = 1'b1;
      end
      OP_I: begin
        case (funct)
          F_LUI, F_LBI: begin
            cls   = CLS_ALU;
            wb_en = 1'b1;
          end
          F_SUI, F_SW: begin
            cls      = CLS_MEM;
            is_store = 1'b1;
          end
          F_SBI, F_SB: begin
            cls      = CLS_MEM;
            is_store = 1'b1;
            is_byte  = 1'b1;
          end
          F_LW: begin
            cls     = CLS_MEM;
            is_load = 1'b1;
            wb_en   = 1'b1;
          end
          F_LB: begin
            cls     = CLS_MEM;
            is_load = 1'b1;
            is_byte = 1'b1;
            wb_en   = 1'b1;
          end
          default: cls = CLS_NOP;
        endcase
      end
      // unused J function codes fall through as NOP
      OP_J: begin
        if (funct == F_JMP || funct == F_JR) cls = CLS_CTRL;
      end
      OP_BR: cls = CLS_CTRL;
      default: cls = CLS_NOP;
    endcase
  end

endmodule

// File: rtl/nq_exec_ctrl.sv
// rtl/nq_exec_ctrl.sv - multi-cycle execute/memory/write-back sequencer
module nq_exec_ctrl
  import nq_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int TO_W        = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       instr_valid,
  output logic       instr_ready,
  input  logic [1:0] op_in,
  input  logic [2:0] funct_in,
  input  logic       bne_cond,
  input  logic       mem_ack,
  output logic       mem_req,
  output logic       mem_byte,
  output logic       memread,
  output logic       memwrite,
  output logic       regwrite,
  output logic       jmp,
  output logic       jr,
  output logic       bne,
  output logic [1:0] pc_sel,
  output logic       flush,
  output logic       stall,
  output logic       timeout_err
);

  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(MEM_TIMEOUT);

  logic [1:0]      state;
  logic [1:0]      op_q;
  logic [2:0]      funct_q;
  logic [TO_W-1:0] to_cnt;
  logic [TO_W-1:0] to_cnt_inc;

  logic [1:0] cls;
  logic       is_load;
  logic       is_store;
  logic       is_byte;
  logic       wb_en;

  nq_ctrl_decode u_decode (
    .op       (op_q),
    .funct    (funct_q),
    .cls      (cls),
    .is_load  (is_load),
    .is_store (is_store),
    .is_byte  (is_byte),
    .wb_en    (wb_en)
  );

  assign to_cnt_inc = to_cnt + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      op_q        <= 2'b00;
      funct_q     <= 3'b000;
      to_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (instr_valid) begin
            op_q    <= op_in;
            funct_q <= funct_in;
            state   <= S_EXEC;
          end
        end
        S_EXEC: begin
          to_cnt <= '0;
          if (cls == CLS_ALU)      state <= S_WB;
          else if (cls == CLS_MEM) state <= S_MEM;
          else                     state <= S_IDLE;
        end
        S_MEM: begin
          // ack takes priority over a timeout landing in the same cycle
          if (mem_ack) begin
            to_cnt <= '0;
            state  <= is_load ? S_WB : S_IDLE;
          end else if (to_cnt_inc == TO_LIMIT) begin
            to_cnt      <= '0;
            timeout_err <= 1'b1;
            state       <= S_IDLE;
          end else begin
            to_cnt <= to_cnt_inc;
          end
        end
        S_WB:    state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  logic in_exec_ctrl;
  logic is_jmp;
  logic is_jr;
  logic is_bne;

  assign in_exec_ctrl = (state == S_EXEC) && (cls == CLS_CTRL);
  assign is_jmp       = in_exec_ctrl && (op_q == OP_J) && (funct_q == F_JMP);
  assign is_jr        = in_exec_ctrl && (op_q == OP_J) && (funct_q == F_JR);
  assign is_bne       = in_exec_ctrl && (op_q == OP_BR);

  always_comb begin
    pc_sel = PC_SEL_PC2;
    if (is_jmp)                   pc_sel = PC_SEL_JMP;
    else if (is_jr)               pc_sel = PC_SEL_REG;
    else if (is_bne && bne_cond)  pc_sel = PC_SEL_BOFF;
  end

  assign instr_ready = (state == S_IDLE);
  assign stall       = ~instr_ready;
  assign jmp         = is_jmp;
  assign jr          = is_jr;
  assign bne         = is_bne;
  assign flush       = is_jmp | is_jr | (is_bne & bne_cond);

  // memread stays up through WB so the memory mux keeps presenting load data
  assign mem_req  = (state == S_MEM);
  assign memread  = is_load && ((state == S_MEM) || (state == S_WB));
  assign memwrite = is_store && (state == S_MEM);
  assign mem_byte = is_byte && (state == S_MEM);
  assign regwrite = wb_en && (state == S_WB);

endmodule

// File: tb/tb_nq_exec_ctrl.sv
// tb/tb_nq_exec_ctrl.sv - directed scoreboard bench for nq_exec_ctrl
module tb_nq_exec_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       instr_valid;
  logic       instr_ready;
  logic [1:0] op_in;
  logic [2:0] funct_in;
  logic       bne_cond;
  logic       mem_ack;
  logic       mem_req;
  logic       mem_byte;
  logic       memread;
  logic       memwrite;
  logic       regwrite;
  logic       jmp;
  logic       jr;
  logic       bne;
  logic [1:0] pc_sel;
  logic       flush;
  logic       stall;
  logic       timeout_err;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int   lat;
    logic mr;
  } wb_t;

  wb_t        wb_q[$];
  logic [1:0] flush_q[$];
  int         cyc = 0;
  int         accept_cyc = 0;

  nq_exec_ctrl #(.MEM_TIMEOUT(4), .TO_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .op_in       (op_in),
    .funct_in    (funct_in),
    .bne_cond    (bne_cond),
    .mem_ack     (mem_ack),
    .mem_req     (mem_req),
    .mem_byte    (mem_byte),
    .memread     (memread),
    .memwrite    (memwrite),
    .regwrite    (regwrite),
    .jmp         (jmp),
    .jr          (jr),
    .bne         (bne),
    .pc_sel      (pc_sel),
    .flush       (flush),
    .stall       (stall),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [2:0] funct);
    logic seen;
    bit   done;
    done        = 0;
    instr_valid = 1'b1;
    op_in       = op;
    funct_in    = funct;
    for (int i = 0; i < 20 && !done; i++) begin
      seen = instr_ready;
      tick();
      if (seen) done = 1;
    end
    instr_valid = 1'b0;
    if (!done) check("accept_timeout", 32'(done), 32'd1);
  endtask

  // scoreboard: pop expected write-back latency/memread and flush pc_sel
  always @(negedge clk) begin
    if (rst) begin
      cyc++;
      if (instr_valid && instr_ready) accept_cyc = cyc;
      if (regwrite) begin
        check("regwrite_expected", 32'(wb_q.size() > 0), 32'd1);
        if (wb_q.size() > 0) begin
          wb_t e;
          e = wb_q.pop_front();
          check("wb_latency", 32'(cyc - accept_cyc), 32'(e.lat));
          check("wb_memread", 32'(memread), 32'(e.mr));
        end
      end
      if (flush) begin
        check("flush_expected", 32'(flush_q.size() > 0), 32'd1);
        if (flush_q.size() > 0) check("flush_pc_sel", 32'(pc_sel), 32'(flush_q.pop_front()));
      end
    end
  end

  initial begin
    rst         = 1'b1;
    instr_valid = 1'b0;
    op_in       = 2'b00;
    funct_in    = 3'b000;
    bne_cond    = 1'b0;
    mem_ack     = 1'b0;

    #3 rst = 1'b0;
    #1;
    check("rst_ready", 32'(instr_ready), 32'd1);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_outs", 32'({mem_req, mem_byte, memread, memwrite, regwrite, jmp, jr, bne, flush}), 32'd0);
    check("rst_pc_sel", 32'(pc_sel), 32'd0);
    check("rst_timeout", 32'(timeout_err), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    tick();
    check("post_rst_ready", 32'(instr_ready), 32'd1);

    // R-type ADD
    wb_q.push_back('{lat: 2, mr: 1'b0});
    issue(2'b00, 3'b101);
    check("add_exec_stall", 32'(stall), 32'd1);
    check("add_exec_regwrite", 32'(regwrite), 32'd0);
    check("add_exec_pc_sel", 32'(pc_sel), 32'd0);
    tick();
    check("add_wb_regwrite", 32'(regwrite), 32'd1);
    check("add_wb_stall", 32'(stall), 32'd1);
    check("add_wb_pc_sel", 32'(pc_sel), 32'd0);
    tick();
    check("add_idle_regwrite", 32'(regwrite), 32'd0);
    check("add_idle_ready", 32'(instr_ready), 32'd1);

    // LW, ack on third MEM cycle
    wb_q.push_back('{lat: 5, mr: 1'b1});
    issue(2'b01, 3'b100);
    check("lw_exec_req", 32'(mem_req), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      if (i == 2) mem_ack = 1'b1;
      check("lw_mem_req", 32'(mem_req), 32'd1);
      check("lw_mem_memread", 32'(memread), 32'd1);
      check("lw_mem_byte", 32'(mem_byte), 32'd0);
      check("lw_mem_memwrite", 32'(memwrite), 32'd0);
    end
    tick();
    mem_ack = 1'b0;
    check("lw_wb_regwrite", 32'(regwrite), 32'd1);
    check("lw_wb_memread", 32'(memread), 32'd1);
    check("lw_wb_req", 32'(mem_req), 32'd0);
    tick();
    check("lw_idle_ready", 32'(instr_ready), 32'd1);
    check("lw_idle_memread", 32'(memread), 32'd0);

    // SB with no ack -> timeout after 4 MEM cycles
    issue(2'b01, 3'b111);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("sb_mem_req", 32'(mem_req), 32'd1);
      check("sb_mem_byte", 32'(mem_byte), 32'd1);
      check("sb_memwrite", 32'(memwrite), 32'd1);
      check("sb_timeout_pending", 32'(timeout_err), 32'd0);
    end
    tick();
    check("sb_to_ready", 32'(instr_ready), 32'd1);
    check("sb_to_err", 32'(timeout_err), 32'd1);
    check("sb_to_req", 32'(mem_req), 32'd0);
    repeat (2) tick();
    check("sb_to_sticky", 32'(timeout_err), 32'd1);

    // control transfers
    flush_q.push_back(2'b01);
    issue(2'b10, 3'b000);
    check("jmp_jmp", 32'(jmp), 32'd1);
    check("jmp_pc_sel", 32'(pc_sel), 32'd1);
    check("jmp_flush", 32'(flush), 32'd1);
    tick();
    check("jmp_idle_outs", 32'({jmp, flush, pc_sel}), 32'd0);
    check("jmp_idle_ready", 32'(instr_ready), 32'd1);

    flush_q.push_back(2'b10);
    issue(2'b10, 3'b001);
    check("jr_jr", 32'(jr), 32'd1);
    check("jr_jmp", 32'(jmp), 32'd0);
    check("jr_pc_sel", 32'(pc_sel), 32'd2);
    tick();

    bne_cond = 1'b1;
    flush_q.push_back(2'b11);
    issue(2'b11, 3'b000);
    check("bne_t_bne", 32'(bne), 32'd1);
    check("bne_t_pc_sel", 32'(pc_sel), 32'd3);
    check("bne_t_flush", 32'(flush), 32'd1);
    tick();

    bne_cond = 1'b0;
    issue(2'b11, 3'b000);
    check("bne_nt_bne", 32'(bne), 32'd1);
    check("bne_nt_pc_sel", 32'(pc_sel), 32'd0);
    check("bne_nt_flush", 32'(flush), 32'd0);
    tick();

    issue(2'b10, 3'b010);
    check("jnop_outs", 32'({jmp, jr, bne, flush, pc_sel}), 32'd0);
    check("jnop_stall", 32'(stall), 32'd1);
    tick();
    check("jnop_ready", 32'(instr_ready), 32'd1);

    // SUI then LBI with valid held high
    instr_valid = 1'b1;
    op_in       = 2'b01;
    funct_in    = 3'b010;
    tick();
    funct_in = 3'b001;
    check("b2b_exec_ready", 32'(instr_ready), 32'd0);
    tick();
    check("b2b_sui_memwrite", 32'(memwrite), 32'd1);
    check("b2b_sui_byte", 32'(mem_byte), 32'd0);
    check("b2b_mem_ready", 32'(instr_ready), 32'd0);
    mem_ack = 1'b1;
    tick();
    check("b2b_idle_ready", 32'(instr_ready), 32'd1);
    check("b2b_idle_req", 32'(mem_req), 32'd0);
    check("b2b_idle_regwrite", 32'(regwrite), 32'd0);
    wb_q.push_back('{lat: 2, mr: 1'b0});
    tick();
    instr_valid = 1'b0;
    mem_ack     = 1'b0;
    check("b2b_lbi_exec_stall", 32'(stall), 32'd1);
    check("b2b_lbi_exec_req", 32'(mem_req), 32'd0);
    tick();
    check("b2b_lbi_wb", 32'(regwrite), 32'd1);
    tick();

    mem_ack = 1'b1;
    repeat (2) tick();
    check("spur_ack_ready", 32'(instr_ready), 32'd1);
    check("spur_ack_req", 32'(mem_req), 32'd0);
    mem_ack = 1'b0;

    // reset in the middle of a load
    issue(2'b01, 3'b100);
    tick();
    check("midrst_req_before", 32'(mem_req), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("midrst_req", 32'(mem_req), 32'd0);
    check("midrst_memread", 32'(memread), 32'd0);
    check("midrst_ready", 32'(instr_ready), 32'd1);
    check("midrst_timeout_clr", 32'(timeout_err), 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (3) tick();
    check("midrst_no_wb", 32'(regwrite), 32'd0);
    check("midrst_idle", 32'(instr_ready), 32'd1);

    check("wb_q_drained", 32'(wb_q.size()), 32'd0);
    check("flush_q_drained", 32'(flush_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
